// File: rtl/cia_icr.sv
// CIA interrupt control register ($D): sticky event latch, mask, IR flag and IRQ output.
// Define CIA_OLD_IRQ_DELAY_EN to drop a timer B event arriving right after an ICR read (6526).
module cia_icr #(
  parameter int FLAG_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       icr_sel,
  input  logic       rd,
  input  logic       we,
  input  logic [7:0] wdata,
  input  logic       ta_underflow,
  input  logic       tb_underflow,
  input  logic       tod_alarm,
  input  logic       sp_done,
  input  logic       flag_n,
  output logic [7:0] rdata,
  output logic       irq_n
);

  localparam int STAGES = (FLAG_SYNC_STAGES < 2) ? 2 : FLAG_SYNC_STAGES;

  logic [3:0]        level_now;
  logic [3:0]        level_prev;
  logic [STAGES-1:0] flag_sync;
  logic              flag_prev;
  logic [4:0]        pulse;
  logic [4:0]        data;
  logic [4:0]        mask;
  logic              ir;
  logic [7:0]        rdata_q;
  logic [7:0]        read_value;
  logic              rd_strobe;
  logic              wr_strobe;
  logic              unused_wdata;

  assign level_now    = {sp_done, tod_alarm, tb_underflow, ta_underflow};
  assign rd_strobe    = icr_sel & rd;
  assign wr_strobe    = icr_sel & we;
  assign read_value   = {ir, 2'b00, data};
  assign unused_wdata = ^wdata[6:5];

`ifdef CIA_OLD_IRQ_DELAY_EN
  logic rd_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_last <= 1'b0;
    end else begin
      rd_last <= rd_strobe;
    end
  end
`endif

  // History flops start high so sources already asserted at reset release are not events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev <= '1;
      flag_sync  <= '1;
      flag_prev  <= 1'b1;
    end else begin
      level_prev <= level_now;
      flag_sync  <= {flag_sync[STAGES-2:0], flag_n};
      flag_prev  <= flag_sync[STAGES-1];
    end
  end

  always_comb begin
    pulse[3:0] = level_now & ~level_prev;
    pulse[4]   = ~flag_sync[STAGES-1] & flag_prev;
`ifdef CIA_OLD_IRQ_DELAY_EN
    if (rd_last) begin
      pulse[1] = 1'b0;
    end
`endif
  end

  // A read clears the latched events but keeps anything arriving in the read cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      ir      <= 1'b0;
      irq_n   <= 1'b1;
      rdata_q <= '0;
    end else if (rd_strobe) begin
      data    <= pulse;
      ir      <= 1'b0;
      irq_n   <= 1'b1;
      rdata_q <= read_value;
    end else begin
      data    <= data | pulse;
      ir      <= ir | (|(data & mask));
      irq_n   <= ~ir;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (wr_strobe) begin
      if (wdata[7]) begin
        mask <= mask | wdata[4:0];
      end else begin
        mask <= mask & ~wdata[4:0];
      end
    end
  end

  assign rdata = rd_strobe ? read_value : rdata_q;

endmodule

// File: tb/tb_cia_icr.sv
// Self-checking bench for cia_icr: directed vector table, async reset check, randomized run vs model.
module tb_cia_icr;

  localparam int S  = 2;
  localparam int NV = 39;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       icr_sel, rd, we;
  logic [7:0] wdata;
  logic       ta_underflow, tb_underflow, tod_alarm, sp_done, flag_n;
  logic [7:0] rdata;
  logic       irq_n;

  cia_icr #(.FLAG_SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .icr_sel(icr_sel), .rd(rd), .we(we), .wdata(wdata),
    .ta_underflow(ta_underflow), .tb_underflow(tb_underflow), .tod_alarm(tod_alarm),
    .sp_done(sp_done), .flag_n(flag_n), .rdata(rdata), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel, rd, we;
    logic [7:0] wdata;
    logic       ta, tb, al, sp, fl;
    logic [7:0] exp_rdata;
    logic       exp_irq_n;
  } vec_t;

  vec_t vecs [NV];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: latched events, mask, IR, IRQ line, last read value.
  logic [4:0] m_data, m_mask;
  logic       m_ir, m_irqn, m_rdlast;
  logic [7:0] m_rdq;
  logic       m_prev [4];
  logic       m_pins [$];

  function automatic vec_t mkv(input logic s, r, w, input logic [7:0] wd,
                               input logic a, b, c, d, f,
                               input logic [7:0] er, input logic ei);
    vec_t v;
    v.sel = s; v.rd = r; v.we = w; v.wdata = wd;
    v.ta = a; v.tb = b; v.al = c; v.sp = d; v.fl = f;
    v.exp_rdata = er; v.exp_irq_n = ei;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    icr_sel = v.sel; rd = v.rd; we = v.we; wdata = v.wdata;
    ta_underflow = v.ta; tb_underflow = v.tb; tod_alarm = v.al;
    sp_done = v.sp; flag_n = v.fl;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_data = '0; m_mask = '0; m_ir = 1'b0; m_irqn = 1'b1; m_rdq = '0; m_rdlast = 1'b0;
    for (int i = 0; i < 4; i++) m_prev[i] = 1'b1;
    m_pins.delete();
    for (int i = 0; i <= S; i++) m_pins.push_back(1'b1);
  endtask

  function automatic logic [7:0] modelRdata();
    return (icr_sel && rd) ? {m_ir, 2'b00, m_data} : m_rdq;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic modelStep();
    logic       src [4];
    logic [4:0] ev;
    logic       rd_now, wr_now;
    src[0] = ta_underflow; src[1] = tb_underflow; src[2] = tod_alarm; src[3] = sp_done;
    for (int i = 0; i < 4; i++) ev[i] = src[i] && !m_prev[i];
    // The pin seen S edges ago is the synchronized value; a 1->0 step there is a FLAG event.
    ev[4] = !m_pins[S-1] && m_pins[S];
`ifdef CIA_OLD_IRQ_DELAY_EN
    if (m_rdlast) ev[1] = 1'b0;
`endif
    rd_now = icr_sel && rd;
    wr_now = icr_sel && we;
    if (rd_now) begin
      m_rdq  = {m_ir, 2'b00, m_data};
      m_data = ev;
      m_ir   = 1'b0;
      m_irqn = 1'b1;
    end else begin
      m_irqn = !m_ir;
      m_ir   = m_ir || ((m_data & m_mask) != 0);
      m_data = m_data | ev;
    end
    if (wr_now) m_mask = wdata[7] ? (m_mask | wdata[4:0]) : (m_mask & ~wdata[4:0]);
    for (int i = 0; i < 4; i++) m_prev[i] = src[i];
    m_pins.push_front(flag_n);
    void'(m_pins.pop_back());
    m_rdlast = rd_now;
  endtask

  initial begin
    vec_t v;
    //                 sel rd we wdata  ta tb al sp fl  rdata  irq_n
    vecs[0]  = mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 1);
    vecs[1]  = mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 1);
    vecs[2]  = mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 1);
    vecs[3]  = mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 1);
    vecs[4]  = mkv(1, 1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 1);
    vecs[5]  = mkv(1, 0, 1, 8'h81, 0, 0, 0, 0, 1, 8'h00, 1);
    vecs[6]  = mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 1);
    vecs[7]  = mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 1);
    vecs[8]  = mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 1);
    vecs[9]  = mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 0);
    vecs[10] = mkv(1, 1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h81, 0);
    vecs[11] = mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h81, 1);
    vecs[12] = mkv(1, 1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 1);
    vecs[13] = mkv(1, 0, 1, 8'h01, 1, 0, 0, 0, 1, 8'h00, 1);
    vecs[14] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h00, 1);
    vecs[15] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h00, 1);
    vecs[16] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h00, 1);
    vecs[17] = mkv(1, 1, 0, 8'h00, 1, 1, 0, 0, 1, 8'h02, 1);
    vecs[18] = mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h02, 1);
    vecs[19] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h02, 1);
    vecs[20] = mkv(1, 0, 1, 8'h82, 1, 1, 0, 0, 1, 8'h02, 1);
    vecs[21] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h02, 1);
    vecs[22] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h02, 1);
    vecs[23] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h02, 0);
    vecs[24] = mkv(1, 1, 0, 8'h00, 1, 1, 0, 0, 1, 8'h82, 0);
    vecs[25] = mkv(1, 0, 1, 8'h9F, 1, 1, 0, 0, 1, 8'h82, 1);
    vecs[26] = mkv(1, 0, 1, 8'h01, 1, 1, 0, 0, 1, 8'h82, 1);
    vecs[27] = mkv(0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h82, 1);
    vecs[28] = mkv(0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h82, 1);
    vecs[29] = mkv(0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h82, 1);
    vecs[30] = mkv(0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h82, 1);
    vecs[31] = mkv(0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h82, 0);
    vecs[32] = mkv(1, 1, 0, 8'h00, 1, 1, 1, 1, 1, 8'h9F, 0);
    vecs[33] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 1, 1, 8'h9F, 1);
    vecs[34] = mkv(1, 1, 0, 8'h00, 1, 1, 1, 1, 1, 8'h00, 1);
    vecs[35] = mkv(0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h00, 1);
    vecs[36] = mkv(0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h00, 1);
    vecs[37] = mkv(1, 1, 0, 8'h00, 1, 1, 1, 1, 1, 8'h84, 0);
    vecs[38] = mkv(0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h84, 1);

    // Reset with timer A already high, then idle.
    rst_n = 1'b0;
    applyStimulus(vecs[0]);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle%0d_irq_n", i), {7'd0, irq_n}, 8'h01);
      @(posedge clk); #1;
    end

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_irq_n", i), {7'd0, irq_n}, {7'd0, vecs[i].exp_irq_n});
      @(posedge clk); #1;
    end

    // Raise IRQ via timer B (mask still has bit 1), then assert reset between clock edges.
    v = vecs[38];
    v.tb = 1'b0;
    applyStimulus(v);
    @(posedge clk); #1;
    v.tb = 1'b1;
    applyStimulus(v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_irq_n", {7'd0, irq_n}, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_irq_n", {7'd0, irq_n}, 8'h01);
    checkOutput("async_reset_rdata", rdata, 8'h00);
    v = mkv(0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00, 1);
    applyStimulus(v);
    @(posedge clk); #1;
    rst_n = 1'b1;
    modelReset();

    for (int n = 0; n < 3000; n++) begin
      icr_sel = 1'($urandom_range(0, 1));
      rd      = ($urandom_range(0, 2) == 0);
      we      = ($urandom_range(0, 3) == 0);
      wdata   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ta_underflow = ~ta_underflow;
      if ($urandom_range(0, 3) == 0) tb_underflow = ~tb_underflow;
      if ($urandom_range(0, 4) == 0) tod_alarm    = ~tod_alarm;
      if ($urandom_range(0, 4) == 0) sp_done      = ~sp_done;
      if ($urandom_range(0, 4) == 0) flag_n       = ~flag_n;
      @(negedge clk);
      checkOutput($sformatf("rand%0d_rdata", n), rdata, modelRdata());
      checkOutput($sformatf("rand%0d_irq_n", n), {7'd0, irq_n}, {7'd0, m_irqn});
      modelStep();
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
